// File: rtl/exe_stage.sv
// exe_stage -- ARM execute stage with the EXE/MEM pipeline register built in.
//
// Builds operand 1 and the Rm operand (optionally forwarded), derives Val2
// from the shifter operand, runs the ALU, owns the NZCV register and
// produces the branch target. Results are registered toward MEM and held
// while sram_freeze is high.
//
// Build option: `EXE_FORWARDING_EN
//   defined   -> sel_src1/sel_src2 pick among ID value, fwd_mem_val and fwd_wb_val
//   undefined -> forwarding inputs are ignored; operands come straight from ID
//
// Ports:
//   clk, rst (async active-low), sram_freeze
//   *_IN          decode-register controls, operands, shifter operand, imm24, dest
//   sel_src*/fwd_* forwarding selects and values
//   Branch_Address, Branch_Taken   combinational branch outputs
//   Status        registered {N,Z,C,V}
//   WB_EN, MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, Dest   EXE/MEM register
module exe_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        sram_freeze,
    input  logic        WB_EN_IN,
    input  logic        MEM_R_EN_IN,
    input  logic        MEM_W_EN_IN,
    input  logic        B_IN,
    input  logic        S_IN,
    input  logic [3:0]  EXE_CMD_IN,
    input  logic [31:0] PC_IN,
    input  logic [31:0] Val_Rn_IN,
    input  logic [31:0] Val_Rm_IN,
    input  logic        imm_IN,
    input  logic [11:0] Shift_operand_IN,
    input  logic [23:0] Signed_imm_24_IN,
    input  logic [3:0]  Dest_IN,
    input  logic [1:0]  sel_src1,
    input  logic [1:0]  sel_src2,
    input  logic [31:0] fwd_mem_val,
    input  logic [31:0] fwd_wb_val,
    output logic [31:0] Branch_Address,
    output logic        Branch_Taken,
    output logic [3:0]  Status,
    output logic        WB_EN,
    output logic        MEM_R_EN,
    output logic        MEM_W_EN,
    output logic [31:0] ALU_Res,
    output logic [31:0] Val_Rm,
    output logic [3:0]  Dest
);

    logic [31:0] val1, rm_val, val2, res;
    logic [3:0]  flags;

    // ---------------- operand forwarding ----------------
`ifdef EXE_FORWARDING_EN
    always_comb begin
        case (sel_src1)
            2'b01:   val1 = fwd_mem_val;
            2'b10:   val1 = fwd_wb_val;
            default: val1 = Val_Rn_IN;
        endcase
        case (sel_src2)
            2'b01:   rm_val = fwd_mem_val;
            2'b10:   rm_val = fwd_wb_val;
            default: rm_val = Val_Rn_IN == Val_Rn_IN ? Val_Rm_IN : Val_Rm_IN;
        endcase
    end
`else
    // Hazards are resolved by stalling, so the forwarding inputs are dead here.
    logic unused_fwd;
    assign unused_fwd = ^{sel_src1, sel_src2, fwd_mem_val, fwd_wb_val};
    assign val1   = Val_Rn_IN;
    assign rm_val = Val_Rm_IN;
`endif

    // ---------------- Val2 generation ----------------
    logic [4:0]  sh_amt;
    logic [63:0] imm_dbl, rm_dbl;
    assign sh_amt = Shift_operand_IN[11:7];
    // Rotations are done by right-shifting a doubled copy; a zero amount
    // naturally returns the original value.
    assign imm_dbl = {24'd0, Shift_operand_IN[7:0], 24'd0, Shift_operand_IN[7:0]}
                     >> {Shift_operand_IN[11:8], 1'b0};
    assign rm_dbl  = {rm_val, rm_val} >> sh_amt;

    always_comb begin
        if (MEM_R_EN_IN | MEM_W_EN_IN)
            val2 = {20'd0, Shift_operand_IN};
        else if (imm_IN)
            val2 = imm_dbl[31:0];
        else begin
            case (Shift_operand_IN[6:5])
                2'b00:   val2 = rm_val << sh_amt;
                2'b01:   val2 = rm_val >> sh_amt;
                2'b10:   val2 = $signed(rm_val) >>> sh_amt;
                default: val2 = rm_dbl[31:0];
            endcase
        end
    end

    // ---------------- ALU ----------------
    // Subtraction is Val1 + ~Val2 + carry_in, so the carry out is NOT borrow.
    logic [32:0] sum;
    logic [31:0] opb;
    logic        cin, arith;

    always_comb begin
        opb   = val2;
        cin   = 1'b0;
        arith = 1'b0;
        res   = 32'd0;
        case (EXE_CMD_IN)
            4'b0001: res = val2;
            4'b1001: res = ~val2;
            4'b0010: arith = 1'b1;
            4'b0011: begin arith = 1'b1; cin = Status[1]; end
            4'b0100: begin arith = 1'b1; opb = ~val2; cin = 1'b1; end
            4'b0101: begin arith = 1'b1; opb = ~val2; cin = Status[1]; end
            4'b0110: res = val1 & val2;
            4'b0111: res = val1 | val2;
            4'b1000: res = val1 ^ val2;
            default: res = 32'd0;
        endcase
        sum = {1'b0, val1} + {1'b0, opb} + {32'd0, cin};
        if (arith)
            res = sum[31:0];
    end

    // Non-arithmetic ops leave C and V as they were.
    assign flags[3] = res[31];
    assign flags[2] = (res == 32'd0);
    assign flags[1] = arith ? sum[32] : Status[1];
    assign flags[0] = arith ? ((val1[31] == opb[31]) && (sum[31] != val1[31])) : Status[0];

    // ---------------- branch ----------------
    assign Branch_Address = PC_IN + {{6{Signed_imm_24_IN[23]}}, Signed_imm_24_IN, 2'b00};
    assign Branch_Taken   = B_IN;

    // ---------------- EXE/MEM register + status ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WB_EN    <= 1'b0;
            MEM_R_EN <= 1'b0;
            MEM_W_EN <= 1'b0;
            ALU_Res  <= 32'd0;
            Val_Rm   <= 32'd0;
            Dest     <= 4'd0;
            Status   <= 4'd0;
        end else if (!sram_freeze) begin
            WB_EN    <= WB_EN_IN;
            MEM_R_EN <= MEM_R_EN_IN;
            MEM_W_EN <= MEM_W_EN_IN;
            ALU_Res  <= res;
            Val_Rm   <= rm_val;
            Dest     <= Dest_IN;
            if (S_IN)
                Status <= flags;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sram_freeze = 1'b0;
    logic        id_wb, id_mr, id_mw, id_b, id_s, id_imm;
    logic [3:0]  id_cmd, id_dest;
    logic [31:0] id_pc, id_rn, id_rm;
    logic [11:0] id_so;
    logic [23:0] id_simm;
    logic [1:0]  sel1, sel2;
    logic [31:0] fmem, fwb;

    logic [31:0] br_addr, alu_res, val_rm;
    logic        br_taken, wb_en, mem_r_en, mem_w_en;
    logic [3:0]  status, dest;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] m_status = 4'd0;

    localparam longint MAXI = 64'sd2147483647;
    localparam longint MINI = -64'sd2147483648;

    exe_stage dut (
        .clk(clk), .rst(rst), .sram_freeze(sram_freeze),
        .WB_EN_IN(id_wb), .MEM_R_EN_IN(id_mr), .MEM_W_EN_IN(id_mw),
        .B_IN(id_b), .S_IN(id_s), .EXE_CMD_IN(id_cmd), .PC_IN(id_pc),
        .Val_Rn_IN(id_rn), .Val_Rm_IN(id_rm), .imm_IN(id_imm),
        .Shift_operand_IN(id_so), .Signed_imm_24_IN(id_simm), .Dest_IN(id_dest),
        .sel_src1(sel1), .sel_src2(sel2), .fwd_mem_val(fmem), .fwd_wb_val(fwb),
        .Branch_Address(br_addr), .Branch_Taken(br_taken), .Status(status),
        .WB_EN(wb_en), .MEM_R_EN(mem_r_en), .MEM_W_EN(mem_w_en),
        .ALU_Res(alu_res), .Val_Rm(val_rm), .Dest(dest)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_fwd(input logic [1:0] sel, input logic [31:0] id, mem, wb);
`ifdef EXE_FORWARDING_EN
        if (sel == 2'd1) return mem;
        if (sel == 2'd2) return wb;
`endif
        return id;
    endfunction

    function automatic logic [31:0] m_ror(input logic [31:0] x, input int n);
        logic [31:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = {y[0], y[31:1]};
        return y;
    endfunction

    // Shifts applied one bit at a time.
    function automatic logic [31:0] m_val2(input logic mem, imm, input logic [11:0] so, input logic [31:0] rm);
        int amt;
        logic [31:0] y;
        if (mem) return {20'd0, so};
        if (imm) return m_ror({24'd0, so[7:0]}, 2 * int'(so[11:8]));
        amt = int'(so[11:7]);
        y = rm;
        for (int i = 0; i < amt; i++)
            case (so[6:5])
                2'd0:    y = {y[30:0], 1'b0};
                2'd1:    y = {1'b0, y[31:1]};
                2'd2:    y = {y[31], y[31:1]};
                default: y = {y[0], y[31:1]};
            endcase
        return y;
    endfunction

    // Returns {N,Z,C,V,result}; carries/overflow from 64-bit integer arithmetic.
    function automatic logic [35:0] m_alu(input logic [3:0] cmd, input logic [31:0] a, b, input logic [3:0] st);
        longint unsigned ua, ub, u;
        longint sa, sb, s;
        logic [31:0] r;
        logic c, v;
        bit ar;
        int k;
        ua = a; ub = b;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        c = st[1]; v = st[0]; ar = 0; r = 32'd0; s = 0;
        case (cmd)
            4'b0001: r = b;
            4'b1001: r = ~b;
            4'b0010, 4'b0011: begin
                k = (cmd == 4'b0011) ? int'(st[1]) : 0;
                u = ua + ub + k; s = sa + sb + k; r = u[31:0];
                c = (u > 64'hFFFF_FFFF); ar = 1;
            end
            4'b0100, 4'b0101: begin
                k = (cmd == 4'b0101) ? int'(!st[1]) : 0;
                u = ua - ub - k; s = sa - sb - k; r = u[31:0];
                c = (ua >= ub + k); ar = 1;
            end
            4'b0110: r = a & b;
            4'b0111: r = a | b;
            4'b1000: r = a ^ b;
            default: r = 32'd0;
        endcase
        if (ar) v = (s > MAXI) || (s < MINI);
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    function automatic logic [31:0] m_branch(input logic [31:0] pc, input logic [23:0] imm);
        return pc + 32'(longint'($signed(imm)) * 4);
    endfunction

    // Predict the values captured at the next edge, then advance one cycle.
    task automatic cycle(output logic [31:0] e_res, output logic [3:0] e_st, output logic [31:0] e_rm);
        logic [31:0] v1, v2;
        logic [3:0] f;
        v1   = m_fwd(sel1, id_rn, fmem, fwb);
        e_rm = m_fwd(sel2, id_rm, fmem, fwb);
        v2   = m_val2(id_mr | id_mw, id_imm, id_so, e_rm);
        {f, e_res} = m_alu(id_cmd, v1, v2, m_status);
        e_st = (id_s && !sram_freeze) ? f : m_status;
        @(posedge clk); #1;
        m_status = e_st;
    endtask

    task automatic drive_op(input logic [3:0] cmd, input logic [31:0] rn, rm, input logic imm,
                            input logic [11:0] so, input logic s, input logic [3:0] d);
        id_cmd = cmd; id_rn = rn; id_rm = rm; id_imm = imm; id_so = so; id_s = s; id_dest = d;
        id_mr = 0; id_mw = 0; id_b = 0; sel1 = 0; sel2 = 0;
    endtask

    function automatic logic [31:0] rv();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 16));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] er, erm; logic [3:0] es;
        drive_op(4'b0010, 32'h1234, 32'h55, 1'b1, 12'h00F, 1'b1, 4'd5);
        id_wb = 1; id_pc = 0; id_simm = 0; fmem = 0; fwb = 0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({wb_en, mem_r_en, mem_w_en, alu_res, val_rm, dest, status} !== 75'd0) begin
            n_err++; $display("FAIL reset_state got %h %h %h want all zero", alu_res, val_rm, status);
        end
        rst = 1;
        cycle(er, es, erm);
        n_cmp++;
        if (alu_res !== 32'h1243 || dest !== 4'd5 || wb_en !== 1'b1) begin
            n_err++; $display("FAIL first_capture got %h/%0d/%b want 00001243/5/1", alu_res, dest, wb_en);
        end
    endtask

    task automatic test_add_flags();
        logic [31:0] er, erm; logic [3:0] es;
        drive_op(4'b0010, 32'h7FFF_FFFF, 32'h0, 1'b1, 12'h001, 1'b1, 4'd3);
        id_wb = 1;
        cycle(er, es, erm);
        n_cmp++;
        if (alu_res !== 32'h8000_0000 || status !== 4'b1001) begin
            n_err++; $display("FAIL add_ovf got %h nzcv=%b want 80000000 nzcv=1001", alu_res, status);
        end
    endtask

    task automatic test_cmp_carry();
        logic [31:0] er, erm; logic [3:0] es;
        drive_op(4'b0100, 32'd5, 32'd5, 1'b0, 12'h000, 1'b1, 4'd0);
        id_wb = 0;
        cycle(er, es, erm);
        n_cmp++;
        if (alu_res !== 32'd0 || status !== 4'b0110 || wb_en !== 1'b0) begin
            n_err++; $display("FAIL cmp got %h nzcv=%b wb=%b want 0 nzcv=0110 wb=0", alu_res, status, wb_en);
        end
        // ADC consumes C=1 from the CMP
        drive_op(4'b0011, 32'd1, 32'd0, 1'b1, 12'h001, 1'b0, 4'd1);
        cycle(er, es, erm);
        n_cmp++;
        if (alu_res !== 32'd3 || status !== 4'b0110) begin
            n_err++; $display("FAIL adc got %h nzcv=%b want 3 nzcv=0110", alu_res, status);
        end
    endtask

    task automatic test_shifter();
        logic [31:0] er, erm; logic [3:0] es;
        drive_op(4'b0001, 32'h0, 32'h0, 1'b1, 12'h4FF, 1'b0, 4'd2);
        cycle(er, es, erm);
        n_cmp++;
        if (alu_res !== 32'hFF00_0000) begin
            n_err++; $display("FAIL imm_rot got %h want ff000000", alu_res);
        end
        drive_op(4'b0001, 32'h0, 32'h8000_0000, 1'b0, 12'h0C4, 1'b0, 4'd2);
        cycle(er, es, erm);
        n_cmp++;
        if (alu_res !== 32'hC000_0000 || val_rm !== 32'h8000_0000) begin
            n_err++; $display("FAIL asr got %h rm %h want c0000000 rm 80000000", alu_res, val_rm);
        end
    endtask

    task automatic test_branch();
        id_pc = 32'h100; id_simm = 24'hFFFFFE; id_b = 1;
        #1;
        n_cmp++;
        if (br_addr !== 32'hF8 || br_taken !== 1'b1) begin
            n_err++; $display("FAIL branch_back got %h/%b want 000000f8/1", br_addr, br_taken);
        end
        id_pc = 32'hFFFF_FFFC; id_simm = 24'h000001; id_b = 0;
        #1;
        n_cmp++;
        if (br_addr !== 32'h0 || br_taken !== 1'b0) begin
            n_err++; $display("FAIL branch_wrap got %h/%b want 00000000/0", br_addr, br_taken);
        end
    endtask

    task automatic test_freeze();
        logic [31:0] er, erm, r_alu; logic [3:0] es, r_st, r_dest;
        drive_op(4'b0010, 32'h10, 32'h0, 1'b1, 12'h005, 1'b1, 4'd7);
        cycle(er, es, erm);
        r_alu = alu_res; r_st = status; r_dest = dest;
        n_cmp++;
        if (alu_res !== 32'h15) begin
            n_err++; $display("FAIL pre_freeze got %h want 00000015", alu_res);
        end
        sram_freeze = 1;
        for (int i = 0; i < 3; i++) begin
            id_cmd = 4'b0100; id_rn = $urandom; id_so = 12'($urandom_range(0, 4095));
            id_dest = 4'(i + 1); id_s = 1; id_pc = $urandom; id_simm = 24'($urandom);
            #1;
            n_cmp++;
            if (br_addr !== m_branch(id_pc, id_simm)) begin
                n_err++; $display("FAIL freeze_branch got %h want %h", br_addr, m_branch(id_pc, id_simm));
            end
            cycle(er, es, erm);
            n_cmp++;
            if (alu_res !== r_alu || dest !== r_dest || status !== r_st) begin
                n_err++; $display("FAIL freeze_hold got %h/%0d/%b want %h/%0d/%b",
                                  alu_res, dest, status, r_alu, r_dest, r_st);
            end
        end
        sram_freeze = 0;
        drive_op(4'b0001, 32'h0, 32'h0, 1'b1, 12'h0AB, 1'b1, 4'd9);
        cycle(er, es, erm);
        n_cmp++;
        if (alu_res !== 32'hAB || dest !== 4'd9 || status !== 4'b0000) begin
            n_err++; $display("FAIL freeze_release got %h/%0d/%b want 000000ab/9/0000", alu_res, dest, status);
        end
    endtask

    task automatic test_forwarding();
        logic [31:0] er, erm, want_res, want_rm; logic [3:0] es;
        drive_op(4'b0010, 32'd100, 32'h1234, 1'b1, 12'h001, 1'b0, 4'd4);
        sel1 = 2'b01; fmem = 32'd10; sel2 = 2'b10; fwb = 32'hABCD;
`ifdef EXE_FORWARDING_EN
        want_res = 32'd11; want_rm = 32'hABCD;
`else
        want_res = 32'd101; want_rm = 32'h1234;
`endif
        cycle(er, es, erm);
        n_cmp++;
        if (alu_res !== want_res || val_rm !== want_rm) begin
            n_err++; $display("FAIL fwd got %h rm %h want %h rm %h", alu_res, val_rm, want_res, want_rm);
        end
        sel1 = 0; sel2 = 0;
    endtask

    task automatic test_random();
        logic [31:0] er, erm, x_res, x_rm; logic [3:0] es, x_dest; logic [2:0] x_ctl;
        x_res = alu_res; x_rm = val_rm; x_dest = dest; x_ctl = {wb_en, mem_r_en, mem_w_en};
        for (int i = 0; i < 400; i++) begin
            id_cmd = 4'($urandom_range(0, 15)); id_rn = rv(); id_rm = rv();
            id_imm = 1'($urandom); id_so = 12'($urandom_range(0, 4095));
            id_s = 1'($urandom); id_dest = 4'($urandom); id_wb = 1'($urandom);
            id_mr = ($urandom_range(0, 7) == 0); id_mw = ($urandom_range(0, 7) == 0);
            id_b = 1'($urandom); id_pc = $urandom; id_simm = 24'($urandom);
            sel1 = 2'($urandom); sel2 = 2'($urandom); fmem = rv(); fwb = rv();
            sram_freeze = ($urandom_range(0, 5) == 0);
            #1;
            n_cmp++;
            if (br_addr !== m_branch(id_pc, id_simm) || br_taken !== id_b) begin
                n_err++; $display("FAIL rnd_branch[%0d] got %h want %h", i, br_addr, m_branch(id_pc, id_simm));
            end
            cycle(er, es, erm);
            if (!sram_freeze) begin
                x_res = er; x_rm = erm; x_dest = id_dest; x_ctl = {id_wb, id_mr, id_mw};
            end
            n_cmp++;
            if (alu_res !== x_res || status !== es) begin
                n_err++; $display("FAIL rnd_alu[%0d] cmd=%b got %h/%b want %h/%b", i, id_cmd, alu_res, status, x_res, es);
            end
            n_cmp++;
            if (val_rm !== x_rm || dest !== x_dest || {wb_en, mem_r_en, mem_w_en} !== x_ctl) begin
                n_err++; $display("FAIL rnd_reg[%0d] got %h/%0d/%b want %h/%0d/%b",
                                  i, val_rm, dest, {wb_en, mem_r_en, mem_w_en}, x_rm, x_dest, x_ctl);
            end
        end
        sram_freeze = 0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] er, erm; logic [3:0] es;
        drive_op(4'b1001, 32'h0, 32'h0, 1'b1, 12'h000, 1'b1, 4'd15);
        id_wb = 1; id_mw = 1;
        cycle(er, es, erm);
        #3;
        rst = 0;
        #1;
        n_cmp++;
        if ({wb_en, mem_r_en, mem_w_en, alu_res, val_rm, dest, status} !== 75'd0) begin
            n_err++; $display("FAIL mid_reset got %h/%0d/%b want all zero", alu_res, dest, status);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (alu_res !== 32'd0 || status !== 4'd0) begin
            n_err++; $display("FAIL reset_hold got %h/%b want 0/0", alu_res, status);
        end
        rst = 1;
        m_status = 4'd0;
    endtask

    initial begin
        test_reset();
        test_add_flags();
        test_cmp_carry();
        test_shifter();
        test_branch();
        test_freeze();
        test_forwarding();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the ARM pipeline with the EXE/MEM pipeline register built in. It consumes the registered decode outputs (control bits, operands, shift operand, 24-bit branch immediate, destination) and computes the second operand (Val2) and the ALU result. It also owns the NZCV status register and produces the branch target. Results are registered toward the memory stage, and the block honours the SRAM freeze.

## Interface
- No parameters; data width fixed at 32.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `sram_freeze`  in  1  hold the EXE/MEM register and the status register.
- `WB_EN_IN`, `MEM_R_EN_IN`, `MEM_W_EN_IN`, `B_IN`, `S_IN`  in  1 each  control bits from the decode register.
- `EXE_CMD_IN`  in  4  ALU command.
- `PC_IN`  in  32  PC+4 of the instruction.
- `Val_Rn_IN`, `Val_Rm_IN`  in  32 each  register operands.
- `imm_IN`  in  1  immediate operand form.
- `Shift_operand_IN`  in  12  shifter operand or LDR/STR offset.
- `Signed_imm_24_IN`  in  24  branch offset, in words.
- `Dest_IN`  in  4  destination register.
- `sel_src1`, `sel_src2`  in  2 each  forwarding selects.
- `fwd_mem_val`, `fwd_wb_val`  in  32 each  forwarded values from MEM and WB.
- `Branch_Address`  out  32  combinational branch target.
- `Branch_Taken`  out  1  combinational, equals `B_IN`.
- `Status`  out  4  registered {N,Z,C,V}.
- `WB_EN`, `MEM_R_EN`, `MEM_W_EN`  out  1 each  registered control bits.
- `ALU_Res`  out  32  registered ALU result.
- `Val_Rm`  out  32  registered store data, after forwarding.
- `Dest`  out  4  registered destination.

## Operation
- Forwarding: `Val1` and the Rm operand are selected by `sel_src1` / `sel_src2`.
  - 00 selects the ID value.
  - 01 selects `fwd_mem_val`.
  - 10 selects `fwd_wb_val`.
  - 11 is treated as 00.
- Val2 generation:
  - When `MEM_R_EN_IN|MEM_W_EN_IN`: zero-extend `Shift_operand_IN[11:0]`.
  - Else when `imm_IN`: `{24'b0,so[7:0]}` rotated right by `2*so[11:8]`.
  - Else: Rm shifted by `so[11:7]`, with the shift type set by `so[6:5]`.
    - 00 = LSL, 01 = LSR, 10 = ASR, 11 = ROR.
    - A shift amount of 0 passes Rm unchanged.
- `EXE_CMD_IN` encoding:
  - 0001 MOV: Val2.
  - 1001 MVN: ~Val2.
  - 0010 ADD/LDR/STR: Val1+Val2.
  - 0011 ADC: Val1+Val2+C.
  - 0100 SUB/CMP: Val1−Val2.
  - 0101 SBC: Val1−Val2−!C.
  - 0110 AND/TST.
  - 0111 ORR.
  - 1000 EOR.
  - Any other code gives result 0.
- Flags: N = res[31]; Z = (res==0).
  - Arithmetic ops: C = bit 32 of the 33-bit sum. For subtraction this is computed as Val1+~Val2+carry_in, so C = NOT borrow. V = signed overflow.
  - Logical, MOV and MVN keep the current C and V.
- `Status` updates at the clock edge when `S_IN=1` and `sram_freeze=0`; otherwise it holds.
- `Branch_Address` = `PC_IN + {{6{imm24[23]}},imm24,2'b00}`, 32-bit wrap-around.

## Timing
- EXE/MEM register latency is 1 cycle; `ALU_Res` reflects the inputs present at the previous rising edge.
- `Branch_Address`, `Branch_Taken` and forwarding are combinational, with zero latency.
- `sram_freeze=1`: every registered output and `Status` hold; combinational outputs still track the inputs.
- Reset (`rst=0`, asynchronous): `WB_EN`, `MEM_R_EN`, `MEM_W_EN`, `ALU_Res`, `Val_Rm`, `Dest` and `Status` all go to 0 immediately.
  - Reset has priority over freeze.
  - Reset mid-operation discards the in-flight result.
  - The first capture happens on the first rising edge after `rst` deasserts.
- Simultaneous `S_IN=1` and `sram_freeze=1`: no flag update.
- ADC/SBC read the registered C value, i.e. flags set by the previous instruction.

## Configuration
- `EXE_FORWARDING_EN`
  - Defined: the forwarding muxes are as described above.
  - Undefined: `sel_src1`, `sel_src2`, `fwd_mem_val` and `fwd_wb_val` are ignored. `Val1=Val_Rn_IN` and Rm=`Val_Rm_IN`, and hazards are resolved by stalling elsewhere.
- The port list is identical in both builds.

## Test plan
- ADD with S: Val_Rn=0x7FFFFFFF, imm=1, so=0x001 → next cycle `ALU_Res`=0x80000000, `Status`=1001 (N=1, V=1).
- CMP with S: Rn=5, Rm=5, register form with shift 0 → `ALU_Res`=0, `Status`=0110 (Z, C); `WB_EN` passes through as 0.
- Immediate rotate: so=0x4FF → Val2=0xFF000000. ASR: Rm=0x80000000, so=0x0C4 (asr #1) with MOV → 0xC0000000.
- Branch: PC_IN=0x100, imm24=0xFFFFFE → `Branch_Address`=0xF8 combinationally, `Branch_Taken`=1.
- Freeze: assert `sram_freeze` for 3 cycles while the inputs change → `ALU_Res`, `Dest` and `Status` unchanged; the new value is captured on the first edge after release.
- Forwarding (with `EXE_FORWARDING_EN`): sel_src1=01, fwd_mem_val=10, ADD immediate 1 → `ALU_Res`=11. Asserting `rst=0` mid-cycle zeroes all registered outputs immediately.
